// File: rtl/alu.sv
// Registered integer ALU for the arm7tdmi datapath.
// The 4-bit alu_control selects the operation combinationally. result and
// zero_flag are captured together on the rising clk edge, so latency is one cycle.
// Optional macro ALU_FLAGS_EN adds three registered outputs:
// carry_flag, overflow_flag and negative_flag.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag
`endif
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_PASS = 4'b1010
  } alu_op_e;

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] res_nxt;
  logic             zero_nxt;

  assign op    = alu_op_e'(alu_control);
  // Only the low log2(WIDTH) bits of B form the shift amount.
  assign shamt = operand_b[SHW-1:0];
  assign slt   = $signed(operand_a) < $signed(operand_b);

`ifdef ALU_FLAGS_EN
  // Compute one extra bit so the carry out and borrow out are available.
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           carry_nxt;
  logic           ovf_nxt;

  assign add_ext = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_ext = {1'b0, operand_a} - {1'b0, operand_b};
  assign sum     = add_ext[WIDTH-1:0];
  assign diff    = sub_ext[WIDTH-1:0];

  // ARM style: carry is the adder carry out for ADD.
  // For SUB, carry is NOT-borrow. Both flags are cleared for every other opcode.
  always_comb begin
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    case (op)
      OP_ADD: begin
        carry_nxt = add_ext[WIDTH];
        ovf_nxt   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        carry_nxt = ~sub_ext[WIDTH];
        ovf_nxt   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      default: ;
    endcase
  end
`else
  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;
`endif

  // Select the next result. Reserved opcodes produce zero.
  always_comb begin
    res_nxt = '0;
    case (op)
      OP_AND:  res_nxt = operand_a & operand_b;
      OP_OR:   res_nxt = operand_a | operand_b;
      OP_ADD:  res_nxt = sum;
      OP_XOR:  res_nxt = operand_a ^ operand_b;
      OP_NOR:  res_nxt = ~(operand_a | operand_b);
      OP_SUB:  res_nxt = diff;
      OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:  res_nxt = operand_a << shamt;
      OP_SRL:  res_nxt = operand_a >> shamt;
      OP_SRA:  res_nxt = $unsigned($signed(operand_a) >>> shamt);
      OP_PASS: res_nxt = operand_b;
      default: res_nxt = '0;
    endcase
  end

  assign zero_nxt = (res_nxt == '0);

  // Register result and flags together so the outputs always describe the same operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= '0;
      zero_flag     <= 1'b1;
`ifdef ALU_FLAGS_EN
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      negative_flag <= 1'b0;
`endif
    end else begin
      result        <= res_nxt;
      zero_flag     <= zero_nxt;
`ifdef ALU_FLAGS_EN
      carry_flag    <= carry_nxt;
      overflow_flag <= ovf_nxt;
      negative_flag <= res_nxt[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu. Expected values are hand-computed constants.
// The flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control;
  logic [31:0] result;
  logic        zero_flag;
`ifdef ALU_FLAGS_EN
  logic        carry_flag;
  logic        overflow_flag;
  logic        negative_flag;
`endif

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_control  (alu_control),
    .result       (result),
    .zero_flag    (zero_flag)
`ifdef ALU_FLAGS_EN
    ,
    .carry_flag   (carry_flag),
    .overflow_flag(overflow_flag),
    .negative_flag(negative_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let it be captured on the next edge, then return 1 time unit later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    operand_a   = a;
    operand_b   = b;
    alu_control = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    operand_a   = $urandom;
    operand_b   = $urandom;
    alu_control = 4'b0010;

    // Reset held while the clock toggles and the operands change.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      operand_a = $urandom;
      operand_b = $urandom;
    end
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero_flag}, 32'd1);
`ifdef ALU_FLAGS_EN
    chk("rst_flags", {29'd0, carry_flag, overflow_flag, negative_flag}, 32'd0);
`endif
    rst_n = 1'b1;

    // First operation after reset is released.
    run_op(32'd23, 32'd42, 4'b0010);
    chk("add_result", result, 32'd65);
    chk("add_zero", {31'd0, zero_flag}, 32'd0);

    // Logic operations.
    run_op(32'd23, 32'd42, 4'b0000);  chk("and", result, 32'd2);
    run_op(32'd23, 32'd42, 4'b0001);  chk("or",  result, 32'd63);
    run_op(32'd23, 32'd42, 4'b0011);  chk("xor", result, 32'd61);
    run_op(32'd23, 32'd42, 4'b0100);  chk("nor", result, 32'hFFFF_FFC0);

    // SUB and SLT.
    run_op(32'd42, 32'd23, 4'b0101);
    chk("sub_result", result, 32'd19);
    chk("sub_zero", {31'd0, zero_flag}, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("sub_carry", {31'd0, carry_flag}, 32'd1);
`endif
    run_op(32'd42, 32'd23, 4'b0110);  chk("slt_false", result, 32'd0);
    run_op(32'd23, 32'd42, 4'b0110);  chk("slt_true", result, 32'd1);
`ifdef ALU_FLAGS_EN
    chk("slt_flags", {30'd0, carry_flag, overflow_flag}, 32'd0);
`endif
    run_op(32'd42, 32'd42, 4'b0101);
    chk("sub_eq_result", result, 32'd0);
    chk("sub_eq_zero", {31'd0, zero_flag}, 32'd1);

    // Wraparound and signed compare.
    run_op(32'hFFFF_FFFF, 32'd1, 4'b0010);
    chk("add_wrap_result", result, 32'd0);
    chk("add_wrap_zero", {31'd0, zero_flag}, 32'd1);
`ifdef ALU_FLAGS_EN
    chk("add_wrap_carry", {31'd0, carry_flag}, 32'd1);
    chk("add_wrap_ovf", {31'd0, overflow_flag}, 32'd0);
`endif
    run_op(32'h8000_0000, 32'd1, 4'b0110);  chk("slt_signed", result, 32'd1);

`ifdef ALU_FLAGS_EN
    run_op(32'h7FFF_FFFF, 32'd1, 4'b0010);
    chk("add_ovf_flags", {29'd0, carry_flag, overflow_flag, negative_flag}, 32'b011);
    run_op(32'd23, 32'd42, 4'b0101);
    chk("sub_borrow_flags", {29'd0, carry_flag, overflow_flag, negative_flag}, 32'b001);
    run_op(32'h8000_0000, 32'd1, 4'b0101);
    chk("sub_ovf_flags", {29'd0, carry_flag, overflow_flag, negative_flag}, 32'b110);
`endif

    // Shift operations. Only the low 5 bits of B (0x24 -> 4) are used.
    run_op(32'h8000_0010, 32'h0000_0024, 4'b0111);  chk("sll", result, 32'h0000_0100);
    run_op(32'h8000_0010, 32'h0000_0024, 4'b1000);  chk("srl", result, 32'h0800_0001);
    run_op(32'h8000_0010, 32'h0000_0024, 4'b1001);  chk("sra", result, 32'hF800_0001);
`ifdef ALU_FLAGS_EN
    chk("sra_neg", {31'd0, negative_flag}, 32'd1);
`endif
    // A shift field of 0 (B = 0x20) leaves A unchanged.
    run_op(32'h8000_0010, 32'h0000_0020, 4'b1001);  chk("sra_amt0", result, 32'h8000_0010);
    run_op(32'h8000_0010, 32'hFFFF_FFE0, 4'b0111);  chk("sll_amt0", result, 32'h8000_0010);
    run_op(32'h0000_0001, 32'h0000_001F, 4'b0111);  chk("sll_max", result, 32'h8000_0000);

    // PASS_B and reserved opcodes.
    run_op(32'h1234_5678, 32'hDEAD_BEEF, 4'b1010);  chk("pass_b", result, 32'hDEAD_BEEF);
    run_op(32'h1234_5678, 32'hDEAD_BEEF, 4'b1011);  chk("op1011", result, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111);
    chk("op1111_result", result, 32'd0);
    chk("op1111_zero", {31'd0, zero_flag}, 32'd1);

    // Reset asserted between edges while a nonzero result is being held.
    run_op(32'd0, 32'd5, 4'b1010);
    chk("pre_rst_result", result, 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_zero", {31'd0, zero_flag}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_hold_result", result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
